// File: rtl/led_engine_sched.sv
// Time-base and run-control scheduler for the 16-LED pattern engine.
// Produces a one-cycle clock enable and sequences en/dir from button pulses and an auto-demo timer.
module led_engine_sched #(
  parameter int DIV_WIDTH  = 25,
  parameter int AUTO_TICKS = 8,
  parameter int HOLD_TICKS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pause_btn,
  input  logic        dir_btn,
  input  logic        auto_sw,
  input  logic [15:0] led_in,
  output logic        tick,
  output logic        en,
  output logic        dir,
  output logic [1:0]  state
);

  localparam int AW = $clog2(AUTO_TICKS) + 1;
  localparam int HW = $clog2(HOLD_TICKS) + 1;
  localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_TICKS - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_PAUSE = 2'd1,
    S_HOLD  = 2'd2,
    S_BAD   = 2'd3
  } state_t;

  state_t                state_r;
  logic [DIV_WIDTH-1:0]  presc;
  logic [AW-1:0]         auto_cnt;
  logic [HW-1:0]         hold_cnt;

  // Free-running prescaler; tick is registered so it lands one cycle after the all-ones count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc <= '0;
      tick  <= 1'b0;
    end else begin
      presc <= presc + DIV_WIDTH'(1);
      tick  <= &presc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= S_RUN;
      dir      <= 1'b0;
      auto_cnt <= '0;
      hold_cnt <= '0;
    end else begin
      case (state_r)
        S_RUN: begin
          if (pause_btn) begin
            state_r <= S_PAUSE;
          end else if (auto_sw && tick && (led_in == 16'hFFFF)) begin
            state_r  <= S_HOLD;
            hold_cnt <= '0;
          end else if (auto_sw && tick) begin
            if (auto_cnt == AUTO_LAST) begin
              auto_cnt <= '0;
              dir      <= ~dir;
            end else begin
              auto_cnt <= auto_cnt + AW'(1);
            end
          end
        end
        S_PAUSE: begin
          if (pause_btn) state_r <= S_RUN;
        end
        S_HOLD: begin
          if (pause_btn) begin
            state_r  <= S_PAUSE;
            hold_cnt <= '0;
          end else if (!auto_sw) begin
            state_r  <= S_RUN;
            hold_cnt <= '0;
          end else if (tick) begin
            if (hold_cnt == HOLD_LAST) begin
              state_r  <= S_RUN;
              hold_cnt <= '0;
            end else begin
              hold_cnt <= hold_cnt + HW'(1);
            end
          end
        end
        default: state_r <= S_RUN;
      endcase

      // Manual mode owns dir and keeps the auto interval parked at zero, so re-entering auto restarts it.
      if (!auto_sw) begin
        auto_cnt <= '0;
        if (dir_btn) dir <= ~dir;
      end
    end
  end

  assign en    = (state_r == S_RUN);
  assign state = state_r;

endmodule

// File: tb/tb_led_engine_sched.sv
// Directed bench for led_engine_sched with a 4-clk tick period, AUTO_TICKS=3, HOLD_TICKS=2.
module tb_led_engine_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pause_btn;
  logic        dir_btn;
  logic        auto_sw;
  logic [15:0] led_in;
  logic        tick;
  logic        en;
  logic        dir;
  logic [1:0]  state;

  int n_cmp = 0;
  int n_bad = 0;

  led_engine_sched #(.DIV_WIDTH(2), .AUTO_TICKS(3), .HOLD_TICKS(2)) dut (
    .clk(clk), .rst_n(rst_n), .pause_btn(pause_btn), .dir_btn(dir_btn),
    .auto_sw(auto_sw), .led_in(led_in), .tick(tick), .en(en), .dir(dir), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled and inputs driven on the falling edge.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic to_tick();
    int n = 0;
    while (tick !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("tick_seen", {31'd0, tick}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; pause_btn = 1'b0; dir_btn = 1'b0; auto_sw = 1'b0; led_in = 16'h00F0;
    cyc(); cyc();
    chk("rst_state", {30'd0, state}, 32'd0);
    chk("rst_en",    {31'd0, en},    32'd1);
    chk("rst_dir",   {31'd0, dir},   32'd0);
    chk("rst_tick",  {31'd0, tick},  32'd0);

    rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      chk($sformatf("tick_k%0d", k), {31'd0, tick}, {31'd0, (k % 4) == 0});
    end

    // Auto mode: dir flips every third tick, dir_btn ignored.
    auto_sw = 1'b1;
    for (int t = 1; t <= 9; t++) begin
      to_tick();
      cyc();
      chk($sformatf("auto_dir_t%0d", t), {31'd0, dir}, {31'd0, ((t / 3) % 2) == 1});
      chk($sformatf("auto_en_t%0d", t), {31'd0, en}, 32'd1);
      dir_btn = 1'b1; cyc(); dir_btn = 1'b0;
    end

    // Dwell on all-on pattern.
    to_tick(); led_in = 16'hFFFF; cyc(); led_in = 16'h00F0;
    chk("hold_state", {30'd0, state}, 32'd2);
    chk("hold_en",    {31'd0, en},    32'd0);
    chk("hold_dir",   {31'd0, dir},   32'd1);
    to_tick(); cyc();
    chk("hold_mid",   {30'd0, state}, 32'd2);
    to_tick(); cyc();
    chk("hold_exit",  {30'd0, state}, 32'd0);
    chk("hold_exen",  {31'd0, en},    32'd1);
    chk("hold_exdir", {31'd0, dir},   32'd1);

    // Pause freezes auto_cnt (here 1) while ticks keep coming.
    to_tick(); cyc();
    pause_btn = 1'b1; cyc(); pause_btn = 1'b0;
    chk("pause_state", {30'd0, state}, 32'd1);
    chk("pause_en",    {31'd0, en},    32'd0);
    to_tick(); cyc();
    to_tick(); cyc();
    chk("pause_dir",   {31'd0, dir},   32'd1);
    pause_btn = 1'b1; cyc(); pause_btn = 1'b0;
    chk("resume_state", {30'd0, state}, 32'd0);
    chk("resume_en",    {31'd0, en},    32'd1);
    to_tick(); cyc();
    chk("resume_dir1", {31'd0, dir}, 32'd1);
    to_tick(); cyc();
    chk("resume_dir2", {31'd0, dir}, 32'd0);

    // Manual mode.
    auto_sw = 1'b0; cyc();
    dir_btn = 1'b1; cyc(); dir_btn = 1'b0;
    chk("man_dir1", {31'd0, dir}, 32'd1);
    dir_btn = 1'b1; cyc(); dir_btn = 1'b0;
    chk("man_dir0", {31'd0, dir}, 32'd0);
    pause_btn = 1'b1; dir_btn = 1'b1; cyc(); pause_btn = 1'b0; dir_btn = 1'b0;
    chk("both_state", {30'd0, state}, 32'd1);
    chk("both_dir",   {31'd0, dir},   32'd1);
    pause_btn = 1'b1; cyc(); pause_btn = 1'b0;
    chk("man_run", {30'd0, state}, 32'd0);

    // Reset in the middle of HOLD with dir=1.
    auto_sw = 1'b1;
    to_tick(); led_in = 16'hFFFF; cyc();
    chk("pre_rst_hold", {30'd0, state}, 32'd2);
    rst_n = 1'b0; cyc(); rst_n = 1'b1;
    chk("mrst_state", {30'd0, state}, 32'd0);
    chk("mrst_en",    {31'd0, en},    32'd1);
    chk("mrst_dir",   {31'd0, dir},   32'd0);
    chk("mrst_tick",  {31'd0, tick},  32'd0);
    for (int k = 1; k <= 4; k++) begin
      cyc();
      chk($sformatf("mrst_tick_k%0d", k), {31'd0, tick}, {31'd0, k == 4});
    end

    // Dropping auto_sw in HOLD returns to RUN on the next clk.
    cyc();
    chk("hold2_state", {30'd0, state}, 32'd2);
    auto_sw = 1'b0; cyc();
    chk("autodrop_state", {30'd0, state}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
